lcd_sched: RTL and testbench
============================

LCD_SCHED -- requirements
Module: lcd_sched

Interface
REQ-001 SHALL provide parameter PAYLOAD_BITS, default 8, width of received byte and LCD data bus.
REQ-002 SHALL provide parameter EN_PULSE_CYC, default 16, LCD_EN_O high time in clocks.
REQ-003 SHALL provide parameter CMD_WAIT_CYC, default 1080, post-pulse wait for ordinary command/data (40 us @ 27 MHz).
REQ-004 SHALL provide parameter CLR_WAIT_CYC, default 44280, post-pulse wait for clear command 0x01 (1.64 ms).
REQ-005 SHALL provide parameter PWRUP_WAIT_CYC, default 405000, wait after reset before first init command (15 ms).
REQ-006 SHALL provide parameter FIFO_DEPTH, default 4, byte buffer entries, power of two.
REQ-007 SHALL provide port CLK_I, input, 1, single clock; all logic on rising edge.
REQ-008 SHALL provide port RST_I, input, 1, asynchronous active-high reset.
REQ-009 SHALL provide port BYTE_I, input, PAYLOAD_BITS, byte from receive path.
REQ-010 SHALL provide port BYTE_VLD_I, input, 1, one-cycle strobe qualifying BYTE_I.
REQ-011 SHALL provide port BYTE_RDY_O, output, 1, high when FIFO not full.
REQ-012 SHALL provide port OVF_O, output, 1, one-cycle pulse when a byte is dropped.
REQ-013 SHALL provide port BUSY_O, output, 1, high unless in IDLE with FIFO empty.
REQ-014 SHALL provide ports LCD_RW_O, LCD_EN_O, LCD_RS_O, outputs, 1 each, HD44780 control lines.
REQ-015 SHALL provide port LCD_DATA_O, output, PAYLOAD_BITS, HD44780 data bus.

Function
REQ-016 SHALL push BYTE_I into FIFO on any edge with BYTE_VLD_I=1 and BYTE_RDY_O=1; BYTE_VLD_I=1 with BYTE_RDY_O=0 SHALL drop the byte and pulse OVF_O next cycle.
REQ-017 SHALL evaluate BYTE_RDY_O from FIFO occupancy before any same-cycle pop; simultaneous pop at full does not admit a push.
REQ-018 SHALL implement states PWRUP, INIT, IDLE, SETUP, PULSE, WAIT.
REQ-019 PWRUP SHALL count PWRUP_WAIT_CYC clocks, then enter INIT; FIFO accepts bytes during PWRUP/INIT.
REQ-020 INIT SHALL issue commands 0x38, 0x0C, 0x06, 0x01 in order, each via SETUP->PULSE->WAIT, then enter IDLE with column=0.
REQ-021 Each transfer: SETUP drives RS/DATA for 1 clock with EN=0; PULSE holds EN=1 for EN_PULSE_CYC clocks with RS/DATA stable; WAIT holds EN=0 for CMD_WAIT_CYC clocks (CLR_WAIT_CYC if command 0x01).
REQ-022 IDLE with FIFO non-empty SHALL pop one byte and enter SETUP; LCD_EN_O rises on the 2nd rising edge after the edge that accepted a byte into an empty FIFO from IDLE.
REQ-023 Popped byte 0x0D SHALL be issued as command 0x01 (RS=0) and reset column to 0; any other byte SHALL be issued as data (RS=1).
REQ-024 LCD_RW_O SHALL be constant 0.
REQ-025 BUSY_O SHALL be 0 only in IDLE with FIFO empty.

Reset
REQ-026 RST_I=1 SHALL immediately force LCD_EN_O=0, LCD_RS_O=0, LCD_RW_O=0, LCD_DATA_O=0, OVF_O=0, BUSY_O=1, BYTE_RDY_O=1, FIFO empty, column=0, state PWRUP with counter cleared.
REQ-027 Reset asserted mid-transfer SHALL abort it; after release the full PWRUP+INIT sequence SHALL rerun.

Configuration
REQ-028 Macro LCD_SCHED_AUTOWRAP_EN defined: 5-bit column counter increments per data write; after the write bringing it to 16 SHALL issue command 0xC0 (CMD_WAIT_CYC) before next pop; at 32 SHALL issue 0x80 and set column=0.
REQ-029 Macro LCD_SCHED_AUTOWRAP_EN undefined: no column counter, no address commands inserted; data written back-to-back, relying on LCD auto-increment.

Verification (EN_PULSE_CYC=2, CMD_WAIT_CYC=4, CLR_WAIT_CYC=8, PWRUP_WAIT_CYC=10, FIFO_DEPTH=4)
REQ-030 Release reset, no input -> after 10 clocks, four EN pulses with DATA 0x38,0x0C,0x06,0x01, RS=0, 2-clock EN each, 4/4/4/8-clock gaps, then BUSY_O=0.
REQ-031 In IDLE, push 0x41 -> EN high on 2nd edge after accept, RS=1, DATA=0x41 stable across pulse, BUSY_O=0 after 4-clock wait.
REQ-032 In IDLE, push 6 bytes on consecutive cycles -> 5 accepted (1 popped immediately plus 4 buffered), 6th sees BYTE_RDY_O=0, OVF_O pulses once, 5 data writes emitted in order.
REQ-033 Push 0x0D -> command 0x01 with RS=0 and 8-clock wait; following 0x42 written as data.
REQ-034 AUTOWRAP_EN defined, push 33 bytes paced by BUSY_O -> 0xC0 command after 16th data, 0x80 after 32nd, 33rd written as data; undefined -> 33 data writes, no commands.
REQ-035 Assert RST_I during PULSE of a data write -> LCD_EN_O=0 and all outputs at reset values same cycle; after release PWRUP/INIT repeats, buffered bytes discarded.

Source files
------------

// File: rtl/lcd_sched.sv
// HD44780 write scheduler: buffers received bytes, runs the power-up/init sequence, then paces
// each byte onto the LCD bus. Define LCD_SCHED_AUTOWRAP_EN to insert line-address commands every 16 characters.
module lcd_sched #(
  parameter int PAYLOAD_BITS   = 8,
  parameter int EN_PULSE_CYC   = 16,
  parameter int CMD_WAIT_CYC   = 1080,
  parameter int CLR_WAIT_CYC   = 44280,
  parameter int PWRUP_WAIT_CYC = 405000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                    CLK_I,
  input  logic                    RST_I,
  input  logic [PAYLOAD_BITS-1:0] BYTE_I,
  input  logic                    BYTE_VLD_I,
  output logic                    BYTE_RDY_O,
  output logic                    OVF_O,
  output logic                    BUSY_O,
  output logic                    LCD_RW_O,
  output logic                    LCD_EN_O,
  output logic                    LCD_RS_O,
  output logic [PAYLOAD_BITS-1:0] LCD_DATA_O
);

  localparam int MAX_A   = (EN_PULSE_CYC > CMD_WAIT_CYC) ? EN_PULSE_CYC : CMD_WAIT_CYC;
  localparam int MAX_B   = (CLR_WAIT_CYC > PWRUP_WAIT_CYC) ? CLR_WAIT_CYC : PWRUP_WAIT_CYC;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int AW      = $clog2(FIFO_DEPTH);

  localparam logic [PAYLOAD_BITS-1:0] CR_BYTE = PAYLOAD_BITS'(8'h0D);
  localparam logic [PAYLOAD_BITS-1:0] CLR_CMD = PAYLOAD_BITS'(8'h01);

  typedef enum logic [2:0] {PWRUP, INIT, IDLE, SETUP, PULSE, WAIT} state_t;

  function automatic logic [PAYLOAD_BITS-1:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    init_cmd = PAYLOAD_BITS'(8'h38);
      3'd1:    init_cmd = PAYLOAD_BITS'(8'h0C);
      3'd2:    init_cmd = PAYLOAD_BITS'(8'h06);
      default: init_cmd = PAYLOAD_BITS'(8'h01);
    endcase
  endfunction

  // byte buffer
  logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]             wr_ptr, rd_ptr, level;
  logic                    full, empty, push, pop, ovf;
  logic [PAYLOAD_BITS-1:0] head;

  assign level = wr_ptr - rd_ptr;
  assign full  = (level == (AW+1)'(FIFO_DEPTH));
  assign empty = (wr_ptr == rd_ptr);
  assign push  = BYTE_VLD_I && !full;
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK_I) begin
    if (push) mem[wr_ptr[AW-1:0]] <= BYTE_I;
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      ovf <= BYTE_VLD_I && full;
    end
  end

  // sequencer
  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [2:0]              init_idx;
  logic                    cur_rs;
  logic [PAYLOAD_BITS-1:0] cur_data;
  logic                    cnt_clr, load, load_rs, init_inc, wait_done;
  logic [PAYLOAD_BITS-1:0] load_data;
`ifdef LCD_SCHED_AUTOWRAP_EN
  logic [4:0]              column;
  logic                    pend, pend_c0, col_clr, pend_clr;
`endif

  // clear needs the long settle time, everything else the short one
  assign wait_done = (!cur_rs && cur_data == CLR_CMD) ? (cnt == CNT_W'(CLR_WAIT_CYC - 1))
                                                      : (cnt == CNT_W'(CMD_WAIT_CYC - 1));

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    pop       = 1'b0;
    load      = 1'b0;
    load_rs   = 1'b0;
    load_data = '0;
    init_inc  = 1'b0;
`ifdef LCD_SCHED_AUTOWRAP_EN
    col_clr   = 1'b0;
    pend_clr  = 1'b0;
`endif
    case (state)
      PWRUP: begin
        if (cnt == CNT_W'(PWRUP_WAIT_CYC - 1)) begin
          state_nxt = INIT;
          cnt_clr   = 1'b1;
        end
      end
      INIT: begin
        load      = 1'b1;
        load_data = init_cmd(init_idx);
        init_inc  = 1'b1;
        state_nxt = SETUP;
        cnt_clr   = 1'b1;
`ifdef LCD_SCHED_AUTOWRAP_EN
        col_clr   = 1'b1;
`endif
      end
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          load      = 1'b1;
          state_nxt = SETUP;
          cnt_clr   = 1'b1;
          if (head == CR_BYTE) begin
            load_data = CLR_CMD;
`ifdef LCD_SCHED_AUTOWRAP_EN
            col_clr   = 1'b1;
`endif
          end else begin
            load_data = head;
            load_rs   = 1'b1;
          end
        end
      end
      SETUP: begin
        state_nxt = PULSE;
        cnt_clr   = 1'b1;
      end
      PULSE: begin
        if (cnt == CNT_W'(EN_PULSE_CYC - 1)) begin
          state_nxt = WAIT;
          cnt_clr   = 1'b1;
        end
      end
      WAIT: begin
        if (wait_done) begin
          cnt_clr = 1'b1;
          if (init_idx != 3'd4) begin
            state_nxt = INIT;
`ifdef LCD_SCHED_AUTOWRAP_EN
          end else if (pend) begin
            load      = 1'b1;
            load_data = pend_c0 ? PAYLOAD_BITS'(8'hC0) : PAYLOAD_BITS'(8'h80);
            pend_clr  = 1'b1;
            state_nxt = SETUP;
`endif
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = PWRUP;
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state    <= PWRUP;
      cnt      <= '0;
      init_idx <= '0;
      cur_rs   <= 1'b0;
      cur_data <= '0;
`ifdef LCD_SCHED_AUTOWRAP_EN
      column   <= '0;
      pend     <= 1'b0;
      pend_c0  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_clr ? '0 : cnt + CNT_W'(1);
      if (init_inc) init_idx <= init_idx + 3'd1;
      if (load) begin
        cur_rs   <= load_rs;
        cur_data <= load_data;
      end
`ifdef LCD_SCHED_AUTOWRAP_EN
      // column wraps 31->0 on the 32nd write, which is exactly the return to line 1
      if (col_clr) begin
        column <= '0;
      end else if (load && load_rs) begin
        column <= column + 5'd1;
        if (column == 5'd15) begin
          pend    <= 1'b1;
          pend_c0 <= 1'b1;
        end else if (column == 5'd31) begin
          pend    <= 1'b1;
          pend_c0 <= 1'b0;
        end
      end
      if (pend_clr) pend <= 1'b0;
`endif
    end
  end

  assign BYTE_RDY_O = !full;
  assign OVF_O      = ovf;
  assign BUSY_O     = !(state == IDLE && empty);
  assign LCD_RW_O   = 1'b0;
  assign LCD_EN_O   = (state == PULSE);
  assign LCD_RS_O   = cur_rs;
  assign LCD_DATA_O = cur_data;

endmodule

// File: tb/tb_lcd_sched.sv
// Scoreboard bench for lcd_sched: expected LCD transfers are queued as bytes are issued and
// checked by an independent bus monitor. Honors LCD_SCHED_AUTOWRAP_EN like the design.
module tb_lcd_sched;
  localparam int EN_W  = 2;
  localparam int CMD_W = 4;
  localparam int CLR_W = 8;
  localparam int PWR_W = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vld = 1'b0;
  logic [7:0] bi  = 8'h00;
  logic       rdy, ovf, busy, rw, en, rs;
  logic [7:0] data;

  lcd_sched #(
    .PAYLOAD_BITS(8), .EN_PULSE_CYC(EN_W), .CMD_WAIT_CYC(CMD_W),
    .CLR_WAIT_CYC(CLR_W), .PWRUP_WAIT_CYC(PWR_W), .FIFO_DEPTH(4)
  ) dut (
    .CLK_I(clk), .RST_I(rst), .BYTE_I(bi), .BYTE_VLD_I(vld), .BYTE_RDY_O(rdy),
    .OVF_O(ovf), .BUSY_O(busy), .LCD_RW_O(rw), .LCD_EN_O(en), .LCD_RS_O(rs),
    .LCD_DATA_O(data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         w;
  } xfer_t;

  xfer_t q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    col   = 0;
  logic  mon_en = 1'b0;
  logic [7:0] bb [8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // reference model: what the LCD bus must show for each accepted byte
  task automatic expect_init();
    q.push_back('{rs: 1'b0, d: 8'h38, w: CMD_W});
    q.push_back('{rs: 1'b0, d: 8'h0C, w: CMD_W});
    q.push_back('{rs: 1'b0, d: 8'h06, w: CMD_W});
    q.push_back('{rs: 1'b0, d: 8'h01, w: CLR_W});
    col = 0;
  endtask

  task automatic expect_byte(input logic [7:0] b);
    if (b == 8'h0D) begin
      q.push_back('{rs: 1'b0, d: 8'h01, w: CLR_W});
      col = 0;
    end else begin
      q.push_back('{rs: 1'b1, d: b, w: CMD_W});
`ifdef LCD_SCHED_AUTOWRAP_EN
      col++;
      if (col == 16) begin
        q.push_back('{rs: 1'b0, d: 8'hC0, w: CMD_W});
      end else if (col == 32) begin
        q.push_back('{rs: 1'b0, d: 8'h80, w: CMD_W});
        col = 0;
      end
`endif
    end
  endtask

  // bus monitor
  logic       prev_en = 1'b0;
  logic       tracking = 1'b0;
  int         plen = 0;
  int         gap = 0;
  int         exp_wait = 0;
  int         cur_w = 0;
  logic       cap_rs = 1'b0;
  logic [7:0] cap_d = 8'h00;
  xfer_t      e;

  always @(negedge clk) begin
    if (rst || !mon_en) begin
      prev_en  = 1'b0;
      tracking = 1'b0;
      plen     = 0;
    end else begin
      if (en && !prev_en) begin
        if (tracking) begin
          chk("gap_min", 32'(gap >= exp_wait + 1), 32'd1);
          tracking = 1'b0;
        end
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_pulse: got rs=%0d data=%0h required none", rs, data);
          cur_w = CMD_W;
        end else begin
          e = q.pop_front();
          chk("pulse_rs", 32'(rs), 32'(e.rs));
          chk("pulse_data", 32'(data), 32'(e.d));
          cur_w = e.w;
        end
        chk("rw", 32'(rw), 32'd0);
        cap_rs = rs;
        cap_d  = data;
        plen   = 1;
      end else if (en) begin
        plen++;
        chk("stable", 32'({rs, data}), 32'({cap_rs, cap_d}));
      end else if (prev_en) begin
        chk("pulse_len", 32'(plen), 32'(EN_W));
        tracking = 1'b1;
        gap      = 1;
        exp_wait = cur_w;
      end else if (tracking) begin
        if (!busy) begin
          chk("wait_len", 32'(gap), 32'(exp_wait));
          tracking = 1'b0;
        end else begin
          gap++;
        end
      end
      prev_en = en;
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 1000);
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic push_burst(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      vld = 1'b1;
      bi  = bb[i];
      expect_byte(bb[i]);
    end
    @(negedge clk);
    vld = 1'b0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_en", 32'(en), 32'd0);
    chk("rst_rs", 32'(rs), 32'd0);
    chk("rst_rw", 32'(rw), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_rdy", 32'(rdy), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_reset_outputs();

    // power-up wait then init sequence
    rst = 1'b0;
    expect_init();
    mon_en = 1'b1;
    for (int i = 0; i < PWR_W; i++) begin
      @(negedge clk);
      chk("pwrup_en", 32'(en), 32'd0);
    end
    wait_idle();
    chk("init_drain", 32'(q.size()), 32'd0);

    // single byte latency: EN rises on the 2nd edge after accept
    @(negedge clk);
    vld = 1'b1;
    bi  = 8'h41;
    expect_byte(8'h41);
    @(negedge clk);
    vld = 1'b0;
    chk("lat_e1", 32'(en), 32'd0);
    @(negedge clk);
    chk("lat_e2", 32'(en), 32'd0);
    @(negedge clk);
    chk("lat_en", 32'(en), 32'd1);
    chk("lat_rs", 32'(rs), 32'd1);
    chk("lat_data", 32'(data), 32'h41);
    wait_idle();
    chk("single_drain", 32'(q.size()), 32'd0);

    // six back-to-back bytes: five fit, the sixth overflows
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("burst_rdy", 32'(rdy), (i < 5) ? 32'd1 : 32'd0);
      vld = 1'b1;
      bi  = 8'h61 + 8'(i);
      if (i < 5) expect_byte(8'h61 + 8'(i));
    end
    @(negedge clk);
    vld = 1'b0;
    chk("ovf_pulse", 32'(ovf), 32'd1);
    @(negedge clk);
    chk("ovf_single", 32'(ovf), 32'd0);
    wait_idle();
    chk("burst_drain", 32'(q.size()), 32'd0);

    // carriage return becomes clear, then ordinary data
    bb[0] = 8'h0D;
    bb[1] = 8'h42;
    push_burst(2);
    wait_idle();
    chk("cr_drain", 32'(q.size()), 32'd0);

    // 33 characters paced by BUSY_O, starting at column 0
    bb[0] = 8'h0D;
    push_burst(1);
    wait_idle();
    for (int i = 0; i < 33; i++) begin
      bb[0] = 8'h20 + 8'(i);
      push_burst(1);
      wait_idle();
    end
    chk("wrap_drain", 32'(q.size()), 32'd0);

    // randomized bursts of up to five bytes from idle
    for (int it = 0; it < 20; it++) begin
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++)
        bb[i] = ($urandom_range(0, 7) == 0) ? 8'h0D : 8'($urandom);
      push_burst(n);
      wait_idle();
      chk("rand_drain", 32'(q.size()), 32'd0);
    end

    // reset in the middle of a data pulse with bytes still buffered
    bb[0] = 8'h51;
    bb[1] = 8'h52;
    bb[2] = 8'h53;
    push_burst(3);
    n = 0;
    while (!en && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("pre_rst_en", 32'(en), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs();
    mon_en = 1'b0;
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    expect_init();
    mon_en = 1'b1;
    wait_idle();
    chk("rerun_drain", 32'(q.size()), 32'd0);
    repeat (5) @(negedge clk);
    chk("no_stale_en", 32'(en), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
